// File: rtl/wb_reg_bank.sv
// rtl/wb_reg_bank.sv - Wishbone pipelined read/write register bank; byte-select writes when WB_REG_BANK_BYTESEL_EN is defined
module wb_reg_bank #(
    parameter int NREGS = 4,
    parameter int DW    = 32,
    parameter int AW    = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [AW-1:0]         wb_adr_i,
    input  logic [DW/8-1:0]       wb_sel_i,
    input  logic [DW-1:0]         wb_dat_i,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  wb_rty_o,
    output logic                  wb_stall_o,
    output logic [DW-1:0]         wb_dat_o,
    output logic [NREGS*DW-1:0]   regs_o,
    output logic [NREGS-1:0]      wr_stb_o
);

    localparam int NB = DW / 8;
    localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

    // Register storage
    logic [DW-1:0] regs_q [NREGS];

    // Request qualification
    logic          wb_en;
    logic          rd_req;
    logic          wr_req;
    logic          adr_ok;
    logic [DW-1:0] rd_data;

    // In-progress flags, one outstanding access per direction
    logic          rip_q;
    logic          wip_q;

    // Read termination stage
    logic          r_ack_q;
    logic          r_err_q;

    // Write stage: captured request, terminated in the following cycle
    logic          w_ack_q;
    logic          w_err_q;
    logic [IW-1:0] w_idx_q;
    logic [DW-1:0] w_dat_q;
    logic [DW-1:0] wr_word;
    logic          term_err;

`ifdef WB_REG_BANK_BYTESEL_EN
    logic [NB-1:0] w_sel_q;
`else
    // Byte selects have no effect on full-word writes
    logic          sel_unused;
    assign sel_unused = ^wb_sel_i;
`endif

    assign wb_en  = wb_cyc_i & wb_stb_i;
    assign rd_req = wb_en & ~wb_we_i & ~rip_q;
    assign wr_req = wb_en &  wb_we_i & ~wip_q;
    assign adr_ok = 32'(wb_adr_i) < NREGS;

    // Read decode and data mux straight from the request; out-of-range reads return zero
    always_comb begin
        rd_data = '0;
        if (adr_ok) begin
            rd_data = regs_q[wb_adr_i[IW-1:0]];
        end
    end

    // Read path: termination and read data registered together at the request edge
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rip_q    <= 1'b0;
            r_ack_q  <= 1'b0;
            r_err_q  <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            r_ack_q <= rd_req &  adr_ok;
            r_err_q <= rd_req & ~adr_ok;
            if (rd_req) begin
                wb_dat_o <= rd_data;
            end
            if (rd_req) begin
                rip_q <= 1'b1;
            end else if (r_ack_q || r_err_q) begin
                rip_q <= 1'b0;
            end
        end
    end

    // Write path: capture request, address and data; decode result drives next-cycle termination
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wip_q   <= 1'b0;
            w_ack_q <= 1'b0;
            w_err_q <= 1'b0;
            w_idx_q <= '0;
            w_dat_q <= '0;
`ifdef WB_REG_BANK_BYTESEL_EN
            w_sel_q <= '0;
`endif
        end else begin
            w_ack_q <= wr_req &  adr_ok;
            w_err_q <= wr_req & ~adr_ok;
            if (wr_req) begin
                w_idx_q <= wb_adr_i[IW-1:0];
                w_dat_q <= wb_dat_i;
`ifdef WB_REG_BANK_BYTESEL_EN
                w_sel_q <= wb_sel_i;
`endif
            end
            if (wr_req) begin
                wip_q <= 1'b1;
            end else if (w_ack_q || w_err_q) begin
                wip_q <= 1'b0;
            end
        end
    end

    // Word to commit: byte-merged with the current contents, or the full write data
    always_comb begin
        wr_word = w_dat_q;
`ifdef WB_REG_BANK_BYTESEL_EN
        for (int b = 0; b < NB; b++) begin
            if (!w_sel_q[b]) begin
                wr_word[b*8 +: 8] = regs_q[w_idx_q][b*8 +: 8];
            end
        end
`endif
    end

    // Register commit at the edge that ends the write ack cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NREGS; k++) begin
                regs_q[k] <= '0;
            end
        end else if (w_ack_q) begin
            regs_q[w_idx_q] <= wr_word;
        end
    end

    // Termination merge: an error in either direction suppresses the ack
    always_comb begin
        term_err   = r_err_q | w_err_q;
        wb_err_o   = term_err;
        wb_ack_o   = (r_ack_q | w_ack_q) & ~term_err;
        wb_rty_o   = 1'b0;
        // No stall is reported while reset holds the bank idle
        wb_stall_o = wb_en & ~(wb_ack_o | wb_err_o) & ~rst_i;
    end

    // Write strobe pulses alongside the write ack, independent of byte selects
    always_comb begin
        wr_stb_o = '0;
        if (w_ack_q) begin
            wr_stb_o[w_idx_q] = 1'b1;
        end
    end

    // Flatten register contents
    always_comb begin
        regs_o = '0;
        for (int k = 0; k < NREGS; k++) begin
            regs_o[k*DW +: DW] = regs_q[k];
        end
    end

endmodule

// File: tb/tb_wb_reg_bank.sv
// tb/tb_wb_reg_bank.sv - directed self-checking bench for wb_reg_bank
module tb_wb_reg_bank;

    localparam int NREGS = 4;
    localparam int DW    = 32;
    localparam int AW    = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  cyc, stb, we;
    logic [AW-1:0]         adr;
    logic [DW/8-1:0]       sel;
    logic [DW-1:0]         dat;
    logic                  ack, err, rty, stall;
    logic [DW-1:0]         dat_o;
    logic [NREGS*DW-1:0]   regs_o;
    logic [NREGS-1:0]      wr_stb;

    int errors = 0;
    int checks = 0;
    int stb_pulses = 0;
    logic [DW-1:0]       exp_regs [NREGS];
    logic [NREGS*DW-1:0] exp_flat;

    wb_reg_bank #(.NREGS(NREGS), .DW(DW), .AW(AW)) dut (
        .clk_i(clk), .rst_i(rst),
        .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat),
        .wb_ack_o(ack), .wb_err_o(err), .wb_rty_o(rty), .wb_stall_o(stall),
        .wb_dat_o(dat_o), .regs_o(regs_o), .wr_stb_o(wr_stb)
    );

    always #5 clk = ~clk;

    always @(negedge clk) stb_pulses = stb_pulses + $countones(wr_stb);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat = '0; sel = '0;
        #1;
    endtask

    task automatic req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] s);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
        #1;
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw, input logic [DW/8-1:0] s);
        logic [DW-1:0] r;
        r = nw;
`ifdef WB_REG_BANK_BYTESEL_EN
        for (int b = 0; b < DW/8; b++) if (!s[b]) r[b*8 +: 8] = old[b*8 +: 8];
`endif
        return r;
    endfunction

    task automatic build_flat();
        for (int k = 0; k < NREGS; k++) exp_flat[k*DW +: DW] = exp_regs[k];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        for (int k = 0; k < NREGS; k++) exp_regs[k] = '0;
        tick(); tick();
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", ack); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
        checks++; if (rty !== 1'b0) begin errors++; $display("FAIL reset_rty got %b exp 0", rty); end
        checks++; if (dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat got %h exp 0", dat_o); end
        checks++; if (regs_o !== '0) begin errors++; $display("FAIL reset_regs got %h exp 0", regs_o); end
        checks++; if (wr_stb !== 4'b0000) begin errors++; $display("FAIL reset_wr_stb got %b exp 0000", wr_stb); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read_zero();
        for (int a = 0; a < NREGS; a++) begin
            req(1'b0, AW'(a), '0, '0);
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rd0_stall a=%0d got %b exp 1", a, stall); end
            tick();
            checks++; if (ack !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL rd0_ack a=%0d got ack=%b err=%b exp ack=1 err=0", a, ack, err); end
            checks++; if (dat_o !== 32'h0) begin errors++; $display("FAIL rd0_dat a=%0d got %h exp 0", a, dat_o); end
            idle();
            tick();
        end
    endtask

    task automatic test_write_read();
        req(1'b1, 8'd2, 32'hDEADBEEF, 4'hF);
        tick();
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL wr_ack got %b exp 1", ack); end
        checks++; if (wr_stb !== 4'b0100) begin errors++; $display("FAIL wr_stb got %b exp 0100", wr_stb); end
        idle();
        exp_regs[2] = 32'hDEADBEEF;
        tick();
        checks++; if (wr_stb !== 4'b0000) begin errors++; $display("FAIL wr_stb_clear got %b exp 0000", wr_stb); end
        checks++; if (regs_o[95:64] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_reg2 got %h exp deadbeef", regs_o[95:64]); end
        req(1'b0, 8'd2, '0, '0);
        tick();
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rdback_ack got %b exp 1", ack); end
        checks++; if (dat_o !== 32'hDEADBEEF) begin errors++; $display("FAIL rdback_dat got %h exp deadbeef", dat_o); end
        idle();
        tick();
    endtask

    task automatic test_bytesel();
        logic [DW-1:0] exp_a, exp_b;
`ifdef WB_REG_BANK_BYTESEL_EN
        exp_a = 32'h11BB33DD;
        exp_b = 32'h11BB33DD;
`else
        exp_a = 32'hAABBCCDD;
        exp_b = 32'h0F0F0F0F;
`endif
        req(1'b1, 8'd1, 32'h11223344, 4'hF); tick(); idle(); tick();
        req(1'b1, 8'd1, 32'hAABBCCDD, 4'b0101); tick(); idle(); tick();
        checks++; if (regs_o[63:32] !== exp_a) begin errors++; $display("FAIL bytesel_0101 got %h exp %h", regs_o[63:32], exp_a); end
        req(1'b1, 8'd1, 32'h0F0F0F0F, 4'b0000); tick();
        checks++; if (ack !== 1'b1 || wr_stb !== 4'b0010) begin errors++; $display("FAIL bytesel_0000_ack got ack=%b stb=%b exp ack=1 stb=0010", ack, wr_stb); end
        idle(); tick();
        checks++; if (regs_o[63:32] !== exp_b) begin errors++; $display("FAIL bytesel_0000 got %h exp %h", regs_o[63:32], exp_b); end
        exp_regs[1] = exp_b;
    endtask

    task automatic test_error();
        build_flat();
        req(1'b1, 8'd4, 32'h12345678, 4'hF);
        tick();
        checks++; if (err !== 1'b1 || ack !== 1'b0) begin errors++; $display("FAIL wr_err got err=%b ack=%b exp err=1 ack=0", err, ack); end
        checks++; if (wr_stb !== 4'b0000) begin errors++; $display("FAIL wr_err_stb got %b exp 0000", wr_stb); end
        idle(); tick();
        checks++; if (regs_o !== exp_flat) begin errors++; $display("FAIL wr_err_regs got %h exp %h", regs_o, exp_flat); end
        req(1'b0, 8'd2, '0, '0); tick(); idle(); tick();
        req(1'b0, 8'd4, '0, '0);
        tick();
        checks++; if (err !== 1'b1 || ack !== 1'b0) begin errors++; $display("FAIL rd_err got err=%b ack=%b exp err=1 ack=0", err, ack); end
        checks++; if (dat_o !== 32'h0) begin errors++; $display("FAIL rd_err_dat got %h exp 0", dat_o); end
        idle(); tick();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", err); end
        req(1'b0, 8'd2, '0, '0); tick(); idle();
        tick(); tick(); tick();
        checks++; if (dat_o !== 32'hDEADBEEF) begin errors++; $display("FAIL dat_hold got %h exp deadbeef", dat_o); end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a_tab [3];
        logic [DW-1:0] d_tab [3];
        int p0;
        a_tab[0] = 8'd0; a_tab[1] = 8'd1; a_tab[2] = 8'd3;
        d_tab[0] = 32'hA0A0A0A0; d_tab[1] = 32'hB1B1B1B1; d_tab[2] = 32'hC3C3C3C3;
        p0 = stb_pulses;
        for (int i = 0; i < 3; i++) begin
            req(1'b1, a_tab[i], d_tab[i], 4'hF);
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_stall beat=%0d got %b exp 1", i, stall); end
            tick();
            checks++; if (ack !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL b2b_ack beat=%0d got ack=%b stall=%b exp ack=1 stall=0", i, ack, stall); end
            checks++; if (wr_stb !== (4'b0001 << a_tab[i])) begin errors++; $display("FAIL b2b_stb beat=%0d got %b exp %b", i, wr_stb, 4'b0001 << a_tab[i]); end
            exp_regs[a_tab[i]] = merge(exp_regs[a_tab[i]], d_tab[i], 4'hF);
            tick();
        end
        idle(); tick();
        build_flat();
        checks++; if (regs_o !== exp_flat) begin errors++; $display("FAIL b2b_regs got %h exp %h", regs_o, exp_flat); end
        checks++; if (stb_pulses - p0 !== 3) begin errors++; $display("FAIL b2b_pulses got %0d exp 3", stb_pulses - p0); end
    endtask

    task automatic test_read_during_commit();
        req(1'b1, 8'd0, 32'h55AA55AA, 4'hF);
        tick();
        req(1'b0, 8'd0, '0, '0);
        tick();
        checks++; if (ack !== 1'b1 || dat_o !== 32'hA0A0A0A0) begin errors++; $display("FAIL rd_commit got ack=%b dat=%h exp ack=1 dat=a0a0a0a0", ack, dat_o); end
        checks++; if (regs_o[31:0] !== 32'h55AA55AA) begin errors++; $display("FAIL rd_commit_reg got %h exp 55aa55aa", regs_o[31:0]); end
        exp_regs[0] = 32'h55AA55AA;
        idle(); tick();
    endtask

    task automatic test_reset_mid();
        req(1'b1, 8'd3, 32'hCAFEF00D, 4'hF);
        tick();
        rst = 1'b1;
        #1;
        checks++; if (ack !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rstmid_term got ack=%b err=%b exp 0 0", ack, err); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall got %b exp 0", stall); end
        checks++; if (wr_stb !== 4'b0000 || dat_o !== 32'h0) begin errors++; $display("FAIL rstmid_out got stb=%b dat=%h exp 0000 0", wr_stb, dat_o); end
        tick();
        idle();
        checks++; if (regs_o !== '0) begin errors++; $display("FAIL rstmid_regs got %h exp 0", regs_o); end
        rst = 1'b0;
        for (int k = 0; k < NREGS; k++) exp_regs[k] = '0;
        tick();
        req(1'b0, 8'd3, '0, '0);
        tick();
        checks++; if (ack !== 1'b1 || dat_o !== 32'h0) begin errors++; $display("FAIL rstmid_rd got ack=%b dat=%h exp ack=1 dat=0", ack, dat_o); end
        idle(); tick();
    endtask

    initial begin
        test_reset();
        test_read_zero();
        test_write_read();
        test_bytesel();
        test_error();
        test_back_to_back();
        test_read_during_commit();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
